uart_image_loader: RTL and testbench
====================================

// Module: uart_image_loader
// PURPOSE
//  Sits between the UART receiver and the input-unit RAM in the SNN top level.
//  - Collects 98 received bytes (one 28x28 binary image, 784 pixels).
//  - Unpacks each byte LSB-first into single-bit RAM writes.
//  - Pulses start to snn_core once the image is complete.
//  - Blocks new image bytes until snn_core reports done.
// PARAMETERS
//  NUM_BITS        784     pixels per image; must be a multiple of 8
//  ADDR_W          10      input-RAM address width; 2**ADDR_W >= NUM_BITS
//  TIMEOUT_CYCLES  1000000 inter-byte idle limit (only with IMG_LOADER_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  rx_rdy      in   1       UART byte valid; level, held until clr_rx_rdy
//  rx_data     in   8       received byte; valid while rx_rdy=1
//  clr_rx_rdy  out  1       1-cycle pulse acknowledging the consumed byte
//  core_done   in   1       1-cycle pulse from snn_core: inference finished
//  ram_we      out  1       input-RAM write enable
//  ram_addr    out  ADDR_W  input-RAM write address
//  ram_din     out  1       pixel bit written
//  start       out  1       1-cycle pulse to snn_core
//  busy        out  1       high from first byte accepted until core_done
// BEHAVIOUR
//  Reset (rst sampled high on a clk edge): all outputs 0, byte/bit counters 0,
//   state WAIT_BYTE. Reset wins over every other event, in any state.
//  States:
//   WAIT_BYTE: if rx_rdy, latch rx_data into shift reg and pulse clr_rx_rdy.
//    Next: UNPACK.
//   UNPACK: 8 consecutive cycles with ram_we=1 and ram_din=shift[0].
//    Shift right each cycle. ram_addr = byte_cnt*8 + bit_idx.
//    After bit 7: byte_cnt++. byte_cnt==NUM_BITS/8 -> START, else -> WAIT_BYTE.
//   START: start=1 for exactly one cycle, byte_cnt cleared. Next: WAIT_DONE.
//   WAIT_DONE: rx_rdy is ignored (no clr_rx_rdy; byte stays pending in UART).
//    core_done -> WAIT_BYTE, busy falls the following cycle.
//  busy: set on the cycle clr_rx_rdy pulses for byte 0; cleared only by
//   core_done or rst.
//  Latency: first RAM write 1 cycle after the clr_rx_rdy cycle. start asserts
//   1 cycle after the final write (addr NUM_BITS-1).
//  rx_rdy rising during UNPACK is held until UNPACK completes; no bytes lost.
//  Addresses never exceed NUM_BITS-1; there is no wrap within an image.
//  core_done outside WAIT_DONE is ignored.
//  ram_we=0 in every state except UNPACK; ram_addr/ram_din are don't-care then.
// CONFIGURATION
//  IMG_LOADER_TIMEOUT_EN defined:
//   - An idle counter runs in WAIT_BYTE while 0 < byte_cnt < NUM_BITS/8.
//   - Reaching TIMEOUT_CYCLES clears byte_cnt and busy; state stays WAIT_BYTE.
//   - The next byte is treated as byte 0; partial image data is overwritten.
//  IMG_LOADER_TIMEOUT_EN undefined: no counter; a partial image waits forever.
// TESTING
//  1. Send 98 bytes of 0xA5 -> 784 writes, ram_din pattern 1,0,1,0,0,1,0,1
//     per byte; start pulses once, after addr 783.
//  2. Byte 0x01 first -> addr 0 gets 1, addrs 1-7 get 0. Byte 0x80 second ->
//     addr 15 gets 1. Check clr_rx_rdy: one pulse per byte.
//  3. Hold rx_rdy high in WAIT_DONE for 50 cycles -> no clr_rx_rdy, no
//     ram_we. Pulse core_done -> byte accepted as byte 0 of the next image.
//  4. Assert rst during UNPACK of byte 40 -> next cycle all outputs 0. Resend
//     98 bytes -> start after exactly 784 writes starting at addr 0.
//  5. (IMG_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100) Send 10 bytes, idle 100
//     cycles -> busy=0. Next byte writes addrs 0-7.
//  6. core_done pulsed in WAIT_BYTE mid-image -> ignored; byte_cnt and busy
//     unchanged.

Source files
------------

// File: rtl/uart_image_loader.sv
// Collects NUM_BITS/8 UART bytes, unpacks them LSB-first into 1-bit input-RAM writes, then starts snn_core.
// Optional inter-byte idle timeout enabled by defining IMG_LOADER_TIMEOUT_EN.
module uart_image_loader #(
   parameter int NUM_BITS = 784,
   parameter int ADDR_W   = 10
`ifdef IMG_LOADER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic              clk,
   input  logic              rst,
   // rx_rdy/rx_data form a level handshake: the byte is consumed on the cycle
   // clr_rx_rdy pulses, and rx_rdy is only sampled while in WAIT_BYTE.
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   output logic              clr_rx_rdy,
   input  logic              core_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_din,
   output logic              start,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int NUM_BYTES = NUM_BITS / 8;
   localparam int BC_W      = $clog2(NUM_BYTES + 1);

   localparam logic [1:0] S_WAIT_BYTE = 2'd0;
   localparam logic [1:0] S_UNPACK    = 2'd1;
   localparam logic [1:0] S_START     = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]      state;
   logic [7:0]      shift;
   logic [2:0]      bit_idx;
   logic [BC_W-1:0] byte_cnt;

`ifdef IMG_LOADER_TIMEOUT_EN
   localparam int IC_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IC_W-1:0] idle_cnt;
`endif

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_WAIT_BYTE;
         shift      <= '0;
         bit_idx    <= '0;
         byte_cnt   <= '0;
         clr_rx_rdy <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= 1'b0;
         start      <= 1'b0;
         busy       <= 1'b0;
`ifdef IMG_LOADER_TIMEOUT_EN
         idle_cnt   <= '0;
`endif
      end else begin
         clr_rx_rdy <= 1'b0;
         ram_we     <= 1'b0;
         start      <= 1'b0;
         case (state)
            S_WAIT_BYTE: begin
               if (rx_rdy) begin
                  shift      <= rx_data;
                  clr_rx_rdy <= 1'b1;
                  bit_idx    <= '0;
                  state      <= S_UNPACK;
                  if (byte_cnt == '0)
                     busy <= 1'b1;
`ifdef IMG_LOADER_TIMEOUT_EN
                  idle_cnt <= '0;
               end else if (byte_cnt != '0) begin
                  // A stalled partial image is abandoned; the next byte restarts at address 0.
                  if (idle_cnt == IC_W'(TIMEOUT_CYCLES - 1)) begin
                     byte_cnt <= '0;
                     busy     <= 1'b0;
                     idle_cnt <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
`endif
               end
            end
            S_UNPACK: begin
               // Writes trail the cycle they are computed in, so the first lands one cycle after clr_rx_rdy.
               ram_we   <= 1'b1;
               ram_addr <= ADDR_W'({byte_cnt, bit_idx});
               ram_din  <= shift[0];
               shift    <= {1'b0, shift[7:1]};
               bit_idx  <= bit_idx + 1'b1;
               if (bit_idx == 3'd7) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  state    <= (byte_cnt == BC_W'(NUM_BYTES - 1)) ? S_START : S_WAIT_BYTE;
               end
            end
            S_START: begin
               start    <= 1'b1;
               byte_cnt <= '0;
               state    <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (core_done) begin
                  busy  <= 1'b0;
                  state <= S_WAIT_BYTE;
               end
            end
            default: state <= S_WAIT_BYTE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader: randomized images against a queue of expected (addr, bit) writes.
// Define IMG_LOADER_TIMEOUT_EN to also exercise the idle timeout with TIMEOUT_CYCLES=100.
module tb_uart_image_loader;

   localparam int NUM_BITS  = 784;
   localparam int ADDR_W    = 10;
   localparam int NUM_BYTES = NUM_BITS / 8;
   localparam int W         = ADDR_W + 1;

   logic              clk;
   logic              rst;
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              clr_rx_rdy;
   logic              core_done;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_din;
   logic              start;
   logic              busy;
   logic [1:0]        dbg_state;

   uart_image_loader #(
      .NUM_BITS(NUM_BITS),
      .ADDR_W(ADDR_W)
`ifdef IMG_LOADER_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_rx_rdy(clr_rx_rdy), .core_done(core_done), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .start(start), .busy(busy),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model: one entry per expected RAM write, {addr, bit}
   logic [W-1:0] exp_q[$];
   int img_byte = 0;
   int sent_cnt = 0;
   int clr_cnt = 0;
   int start_cnt = 0;
   int exp_start_cnt = 0;
   int img_writes = 0;
   logic prev_we = 1'b0;
   logic prev_clr = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;

   // scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst) begin
         img_writes = 0;
         prev_we = 1'b0;
         prev_clr = 1'b0;
      end else begin
         if (ram_we) begin
            total++;
            img_writes++;
            if (exp_q.size() == 0) begin
               bad++;
               $error("FAIL unexpected_write observed addr=%0d din=%0d expected no write", ram_addr, ram_din);
            end else begin
               e = exp_q.pop_front();
               assert ({ram_addr, ram_din} === e) else begin
                  bad++;
                  $error("FAIL ram_write observed addr=%0d din=%0d expected addr=%0d din=%0d",
                         ram_addr, ram_din, e[W-1:1], e[0]);
               end
            end
         end
         if (clr_rx_rdy) begin
            clr_cnt++;
            total++;
            assert (!prev_clr) else begin
               bad++;
               $error("FAIL clr_pulse_width observed two-cycle pulse expected one cycle");
            end
         end
         if (start) begin
            start_cnt++;
            total++;
            assert (prev_we && prev_addr == ADDR_W'(NUM_BITS - 1) && img_writes == NUM_BITS && exp_q.size() == 0)
            else begin
               bad++;
               $error("FAIL start_timing observed prev_we=%0d prev_addr=%0d writes=%0d pending=%0d expected 1/%0d/%0d/0",
                      prev_we, prev_addr, img_writes, exp_q.size(), NUM_BITS - 1, NUM_BITS);
            end
            img_writes = 0;
         end
         prev_we = ram_we;
         prev_addr = ram_addr;
         prev_clr = clr_rx_rdy;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // driver: present a byte, wait for the acknowledge, record the expected writes
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      rx_data = b;
      rx_rdy = 1'b1;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!clr_rx_rdy && n < 40);
      check("byte_accepted", clr_rx_rdy, 1);
      rx_rdy = 1'b0;
      rx_data = 8'($urandom);
      for (int i = 0; i < 8; i++)
         exp_q.push_back({ADDR_W'(img_byte * 8 + i), b[i]});
      if (img_byte == 0)
         check("busy_first_byte", busy, 1);
      img_byte++;
      sent_cnt++;
      if (img_byte == NUM_BYTES) begin
         img_byte = 0;
         exp_start_cnt++;
      end
      tick(gap);
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!start && n < 40);
      check("start_seen", start, 1);
      check("busy_at_start", busy, 1);
   endtask

   task automatic finish_core();
      tick($urandom_range(1, 6));
      check("state_wait_done", dbg_state, 3);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      check("busy_fall", busy, 0);
   endtask

   task automatic send_random(input int count);
      for (int k = 0; k < count; k++)
         send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
   endtask

   initial begin
      #2_000_000;
      $error("FAIL watchdog observed no completion expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int clr_before;
      rst = 1'b1;
      rx_rdy = 1'b0;
      rx_data = 8'h00;
      core_done = 1'b0;
      tick(3);
      check("rst_ram_we", ram_we, 0);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_clr", clr_rx_rdy, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      tick(2);

      // all-0xA5 image
      for (int k = 0; k < NUM_BYTES; k++)
         send_byte(8'hA5, 0);
      wait_start();
      check("clr_per_byte_img1", clr_cnt, sent_cnt);
      finish_core();

      // 0x01 then 0x80, stray core_done mid-image, random remainder
      send_byte(8'h01, $urandom_range(0, 3));
      send_byte(8'h80, $urandom_range(0, 3));
      send_random(8);
      tick(12);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      check("core_done_ignored_busy", busy, 1);
      check("core_done_ignored_state", dbg_state, 0);
      send_random(NUM_BYTES - 10);
      wait_start();
      check("clr_per_byte_img2", clr_cnt, sent_cnt);
      finish_core();

      // byte held pending through WAIT_DONE becomes byte 0 of the next image
      send_random(NUM_BYTES);
      wait_start();
      rx_data = 8'($urandom);
      rx_rdy = 1'b1;
      clr_before = clr_cnt;
      tick(50);
      check("no_clr_in_wait_done", clr_cnt - clr_before, 0);
      check("still_wait_done", dbg_state, 3);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      check("busy_fall_pending", busy, 0);
      send_byte(rx_data, 0);
      send_random(NUM_BYTES - 1);
      wait_start();
      finish_core();

      // reset in the middle of unpacking byte 40
      send_random(40);
      send_byte(8'($urandom_range(0, 255)), 0);
      tick(3);
      check("mid_unpack_we", ram_we, 1);
      rst = 1'b1;
      exp_q.delete();
      img_byte = 0;
      exp_start_cnt = start_cnt;
      tick(1);
      check("rst2_ram_we", ram_we, 0);
      check("rst2_start", start, 0);
      check("rst2_busy", busy, 0);
      check("rst2_clr", clr_rx_rdy, 0);
      check("rst2_addr", ram_addr, 0);
      check("rst2_din", ram_din, 0);
      check("rst2_state", dbg_state, 0);
      rst = 1'b0;
      tick(1);
      send_random(NUM_BYTES);
      wait_start();
      finish_core();

`ifdef IMG_LOADER_TIMEOUT_EN
      // partial image abandoned after the idle limit
      send_random(10);
      tick(120);
      check("timeout_busy", busy, 0);
      img_byte = 0;
      img_writes = 0;
      send_byte(8'($urandom_range(0, 255)), 0);
      send_random(NUM_BYTES - 1);
      wait_start();
      finish_core();
`endif

      tick(5);
      check("queue_drained", exp_q.size(), 0);
      check("start_count", start_cnt, exp_start_cnt);
      check("clr_count", clr_cnt, sent_cnt);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
